// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Main control state machine for the multicycle MIPS datapath. Sequences
// fetch / decode / execute / memory / writeback and drives every datapath
// enable and mux select. Outputs are Moore (registered alongside the state),
// except the fetch and memory-access enables, which are qualified by
// mem_ready so an access completes in the cycle memory reports ready.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   opcode     instruction register bits [31:26]
//   mem_ready  memory completes the current access this cycle
//   IRWrite    load instruction register
//   PCWrite    unconditional PC write
//   Branch     conditional PC write (datapath ANDs with zero)
//   MemWrite   memory write strobe
//   MemRead    memory read request
//   RegWrite   register file write
//   IorD       0 = PC address, 1 = ALUOut address
//   MemtoReg   0 = ALUOut, 1 = MDR
//   RegDst     0 = rt, 1 = rd
//   ALUSrcA    0 = PC, 1 = A
//   ALUSrcB    00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
//   ALUOp      00 = add, 01 = sub, 10 = funct-decoded
//   PCSrc      00 = ALU result, 01 = ALUOut, 10 = jump target
//   illegal_op one-cycle pulse, unknown opcode seen in DECODE
//   state_dbg  current state encoding
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | read registers, precompute branch target, dispatch on opcode
// MEMADR | compute load/store effective address
// MEMRD  | load: read data memory, wait for mem_ready
// MEMWB  | load: write MDR into rt
// MEMWR  | store: write data memory, strobe on mem_ready
// EXEC   | R-type: ALU operation on A, B
// ALUWB  | R-type: write ALUOut into rd
// BRANCH | beq: compare A, B and conditionally load branch target
// ADDIEX | addi: A + signext imm
// ADDIWB | addi: write ALUOut into rt
// JUMP   | j: load jump target into PC
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Per-state control word. fetch and mem_write are qualified by
    // mem_ready at the output; the rest drive the datapath directly.
    typedef struct packed {
        logic       fetch;
        logic       pc_jump;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_q;

    logic op_rtype;
    logic op_lw;
    logic op_sw;
    logic op_beq;
    logic op_addi;
    logic op_j;
    logic op_legal;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch    = 1'b1;
                c.mem_read = 1'b1;
                c.alusrcb  = 2'b01;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write = 1'b1;
                c.memtoreg  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.regdst    = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_jump = 1'b1;
                c.pcsrc   = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_rtype = (opcode == OP_RTYPE);
        op_lw    = (opcode == OP_LW);
        op_sw    = (opcode == OP_SW);
        op_beq   = (opcode == OP_BEQ);
        op_addi  = (opcode == OP_ADDI);
        op_j     = (opcode == OP_J);
        op_legal = op_rtype | op_lw | op_sw | op_beq | op_addi | op_j;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (op_lw || op_sw)  next_state = S_MEMADR;
                else if (op_rtype)   next_state = S_EXEC;
                else if (op_beq)     next_state = S_BRANCH;
                else if (op_addi)    next_state = S_ADDIEX;
                else if (op_j)       next_state = S_JUMP;
                else                 next_state = S_FETCH;
            end
            S_MEMADR: next_state = op_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // The control word is registered from next_state so it lines up with
    // the state register; reset loads the FETCH selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            ctrl_q <= decode_ctrl(S_FETCH);
        end else begin
            state  <= next_state;
            ctrl_q <= decode_ctrl(next_state);
        end
    end

    // Enables are forced low while rst_n is held: state sits in FETCH during
    // reset, and without the gate IRWrite/PCWrite would follow mem_ready.
    assign IRWrite    = rst_n & ctrl_q.fetch & mem_ready;
    assign PCWrite    = rst_n & ((ctrl_q.fetch & mem_ready) | ctrl_q.pc_jump);
    assign Branch     = rst_n & ctrl_q.branch;
    assign MemWrite   = rst_n & ctrl_q.mem_write & mem_ready;
    assign MemRead    = rst_n & ctrl_q.mem_read;
    assign RegWrite   = rst_n & ctrl_q.reg_write;
    assign IorD       = ctrl_q.iord;
    assign MemtoReg   = ctrl_q.memtoreg;
    assign RegDst     = ctrl_q.regdst;
    assign ALUSrcA    = ctrl_q.alusrca;
    assign ALUSrcB    = ctrl_q.alusrcb;
    assign ALUOp      = ctrl_q.aluop;
    assign PCSrc      = ctrl_q.pcsrc;
    assign illegal_op = rst_n & (state == S_DECODE) & ~op_legal;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. The reference model tracks each
// instruction as its list of visited states and advances through the list
// (holding in memory-wait states while mem_ready is low); expected outputs
// per cycle come from a state -> control table.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IRWrite, PCWrite, Branch, MemWrite, MemRead, RegWrite;
    logic       IorD, MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // model
    int         m_seq[5];
    int         m_len = 1;
    int         m_idx = 0;
    logic [5:0] cur_op = 6'b0;
    logic [5:0] pend[$];
    logic [5:0] legal_ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    // segment counters from observed outputs
    int n_mw, n_rw, n_ill, n_br;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs_vec();
        return {IRWrite, PCWrite, Branch, MemWrite, MemRead, RegWrite,
                IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
    endfunction

    // Expected control word for a state (spec encoding) given mem_ready.
    function automatic logic [15:0] exp_vec(input int s, input logic mr);
        logic       irw, pcw, br, mw, mrd, rw, iord, m2r, rd, sa;
        logic [1:0] sb, op, ps;
        {irw, pcw, br, mw, mrd, rw, iord, m2r, rd, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (s)
            0:  begin irw = mr; pcw = mr; mrd = 1'b1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = mr; iord = 1'b1; end
            6:  begin sa = 1'b1; op = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin sa = 1'b1; op = 2'b01; ps = 2'b01; br = 1'b1; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: rw = 1'b1;
            11: begin pcw = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {irw, pcw, br, mw, mrd, rw, iord, m2r, rd, sa, sb, op, ps};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_seq(input logic [5:0] op);
        case (op)
            OP_LW:    begin m_seq = '{0, 1, 2, 3, 4};  m_len = 5; end
            OP_SW:    begin m_seq = '{0, 1, 2, 5, 0};  m_len = 4; end
            OP_RTYPE: begin m_seq = '{0, 1, 6, 7, 0};  m_len = 4; end
            OP_ADDI:  begin m_seq = '{0, 1, 9, 10, 0}; m_len = 4; end
            OP_BEQ:   begin m_seq = '{0, 1, 8, 0, 0};  m_len = 3; end
            OP_J:     begin m_seq = '{0, 1, 11, 0, 0}; m_len = 3; end
            default:  begin m_seq = '{0, 1, 0, 0, 0};  m_len = 2; end
        endcase
    endtask

    function automatic logic [5:0] next_op();
        logic [5:0] op;
        if (pend.size() > 0) begin
            op = pend.pop_front();
        end else if ($urandom_range(0, 4) != 0) begin
            op = legal_ops[$urandom_range(0, 5)];
        end else begin
            op = 6'($urandom_range(0, 63));
        end
        return op;
    endfunction

    function automatic int model_state();
        return (m_idx == 0) ? 0 : m_seq[m_idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        n_mw = 0; n_rw = 0; n_ill = 0; n_br = 0;
    endtask

    // One clock: drive mem_ready, check at the falling edge, advance model.
    task automatic step(input logic mr);
        int s;
        mem_ready = mr;
        @(negedge clk);
        s = model_state();
        chk("state_dbg", 32'(state_dbg), 32'(s));
        chk("controls", 32'(obs_vec()), 32'(exp_vec(s, mr)));
        chk("illegal_op", 32'(illegal_op), 32'((s == 1) && !is_legal(cur_op)));
        chk("exclusive_enables", 32'((PCWrite & Branch) | (MemWrite & RegWrite)), 32'd0);
        n_mw  += int'(MemWrite);
        n_rw  += int'(RegWrite);
        n_ill += int'(illegal_op);
        n_br  += int'(Branch);
        @(posedge clk);
        #1;
        if (!((s == 0 || s == 3 || s == 5) && !mr)) begin
            if (m_idx == 0) begin
                cur_op = next_op();
                opcode = cur_op;
                load_seq(cur_op);
            end
            m_idx++;
            if (m_idx >= m_len) m_idx = 0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        clear_counts();

        // reset held with mem_ready high
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state_dbg), 32'd0);
        chk("reset_irwrite", 32'(IRWrite), 32'd0);
        chk("reset_pcwrite", 32'(PCWrite), 32'd0);
        chk("reset_controls", 32'(obs_vec()), 32'({10'b0, 2'b01, 4'b0}));
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_idx = 0;

        // LW, mem_ready high: 5 cycles, one register write
        pend.push_back(OP_LW);
        clear_counts();
        repeat (5) step(1'b1);
        chk("lw_regwrite_count", 32'(n_rw), 32'd1);
        chk("lw_back_to_fetch", 32'(state_dbg), 32'd0);

        // SW with 3 wait cycles in MEMWR
        pend.push_back(OP_SW);
        repeat (3) step(1'b1);
        clear_counts();
        repeat (3) step(1'b0);
        chk("sw_no_early_write", 32'(n_mw), 32'd0);
        step(1'b1);
        chk("sw_single_pulse", 32'(n_mw), 32'd1);
        chk("sw_back_to_fetch", 32'(state_dbg), 32'd0);

        // R-type then BEQ back-to-back
        pend.push_back(OP_RTYPE);
        pend.push_back(OP_BEQ);
        clear_counts();
        repeat (7) step(1'b1);
        chk("rb_regwrite_count", 32'(n_rw), 32'd1);
        chk("rb_branch_count", 32'(n_br), 32'd1);

        // illegal opcode
        pend.push_back(6'b111111);
        clear_counts();
        repeat (2) step(1'b1);
        chk("ill_pulse_count", 32'(n_ill), 32'd1);
        chk("ill_no_regwrite", 32'(n_rw), 32'd0);
        chk("ill_no_memwrite", 32'(n_mw), 32'd0);
        chk("ill_back_to_fetch", 32'(state_dbg), 32'd0);

        // J, then async reset in EXEC of the following R-type
        pend.push_back(OP_J);
        pend.push_back(OP_RTYPE);
        repeat (5) step(1'b1);
        chk("pre_reset_exec", 32'(state_dbg), 32'd6);
        mem_ready = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(state_dbg), 32'd0);
        chk("async_reset_regwrite", 32'(RegWrite), 32'd0);
        chk("async_reset_controls", 32'(obs_vec()), 32'({10'b0, 2'b01, 4'b0}));
        clear_counts();
        repeat (2) begin
            @(negedge clk);
            n_rw += int'(RegWrite);
        end
        chk("reset_hold_no_regwrite", 32'(n_rw), 32'd0);
        chk("reset_hold_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_idx = 0;
        pend.delete();

        // randomized instruction stream with random memory stalls
        repeat (600) step($urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath.
- Consumes the opcode field held in the instruction register and a memory-ready handshake.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath enable and mux select, including the instruction register's IRWrite.
- Moore outputs, except fetch and memory-access enables, which are gated by mem_ready.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional PC write (datapath ANDs with zero)
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read request
- RegWrite  out  1  register file write
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegDst  out  1  0 = rt, 1 = rd
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse, unknown opcode in DECODE
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 unreachable and return to FETCH.
- Reset:
  - rst_n low asynchronously forces state = FETCH.
  - While rst_n is low, all enables (IRWrite, PCWrite, Branch, MemWrite, MemRead, RegWrite) and illegal_op are 0.
  - Mux selects take their FETCH values.
  - Reset mid-instruction abandons it; no partial writes occur after reset asserts.
- Outputs that are 0 unless listed per state below: all enables, selects, ALUOp and PCSrc (each defaults to 0).
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when 1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if LW, MEMWR if SW.
- MEMRD:
  - MemRead=1, IorD=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next FETCH.
- MEMWR:
  - MemWrite=mem_ready, IorD=1; MemWrite is a single-cycle strobe.
  - Wait for mem_ready, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next FETCH.
- Cycle counts with mem_ready constantly 1:
  - LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3.
  - Illegal opcode: 2 cycles.
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR. It is stable there because IRWrite fires only on the FETCH exit edge.
- At most one of PCWrite/Branch is high in any cycle. MemWrite and RegWrite are never high together.

Test Plan:
- Reset: hold rst_n=0 with mem_ready=1 -> state_dbg=0, IRWrite=0, PCWrite=0. Release -> IRWrite=1 in the first cycle.
- LW with mem_ready=1: states 0,1,2,3,4,0 -> RegWrite=1 and MemtoReg=1 only in MEMWB; 5 cycles total.
- SW with mem_ready low for 3 cycles in MEMWR -> MemWrite=0 for 3 cycles, then exactly one MemWrite pulse, then FETCH.
- R-type then BEQ back-to-back -> ALUWB has RegDst=1; BRANCH has Branch=1, ALUOp=01, PCSrc=01; no PCWrite in BRANCH.
- opcode=6'b111111 -> illegal_op pulses once in DECODE, back to FETCH, no RegWrite/MemWrite asserted.
- J instruction, rst_n dropped asynchronously mid-EXEC of a following R-type -> state_dbg=0 immediately, no RegWrite afterwards.
